// File: rtl/prime_checker_seq.sv
// Sequential prime tester: trial division by odd divisors 3, 5, 7, ... using a
// multi-cycle restoring divider; one start per operand, result flagged by a done pulse.
module prime_checker_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic             res
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, INIT, SQ, DIV, REM, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   n, d, q;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] d_sq;
    logic               sq_gt_n;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic               trivial;
    logic               last_bit;

    // d*d is formed at double width so the square never wraps
    assign d_sq     = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    assign sq_gt_n  = d_sq > {{WIDTH{1'b0}}, n};
    assign shifted  = {rem[WIDTH-1:0], q[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, d};
    assign trivial  = (n <= WIDTH'(3)) || !n[0];
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = INIT;
            INIT:    state_nx = trivial ? DONE : SQ;
            SQ:      state_nx = sq_gt_n ? DONE : DIV;
            DIV:     if (last_bit) state_nx = REM;
            REM:     state_nx = (rem == '0) ? DONE : SQ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n   <= '0;
            d   <= '0;
            q   <= '0;
            rem <= '0;
            cnt <= '0;
            res <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n   <= num;
                        res <= 1'b0;
                    end
                end
                INIT: begin
                    if (n < WIDTH'(2))       res <= 1'b0;
                    else if (n <= WIDTH'(3)) res <= 1'b1;
                    else if (!n[0])          res <= 1'b0;
                    else                     d   <= WIDTH'(3);
                end
                SQ: begin
                    if (sq_gt_n) begin
                        res <= 1'b1;
                    end else begin
                        rem <= '0;
                        q   <= n;
                        cnt <= '0;
                    end
                end
                DIV: begin
                    // restore when the trial subtraction goes negative
                    if (trial[WIDTH+1]) rem <= shifted;
                    else                rem <= trial[WIDTH:0];
                    q   <= {q[WIDTH-2:0], ~trial[WIDTH+1]};
                    cnt <= cnt + CW'(1);
                end
                REM: begin
                    if (rem == '0) res <= 1'b0;
                    else           d   <= d + WIDTH'(2);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_checker_seq.sv
// Bench for prime_checker_seq: an 8-bit and a 4-bit instance driven by directed and
// random operands, compared against an arithmetic primality and latency model.
`timescale 1ns/1ps
module tb_prime_checker_seq;

    logic       clk;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] num8;
    logic [3:0] num4;
    logic       busy8, done8, res8;
    logic       busy4, done4, res4;

    int errors;
    int checks;

    prime_checker_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .num(num8),
        .busy(busy8), .done(done8), .res(res8)
    );

    prime_checker_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .num(num4),
        .busy(busy4), .done(done4), .res(res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_prime(input int v);
        if (v < 2) return 1'b0;
        for (int i = 2; i * i <= v; i++)
            if (v % i == 0) return 1'b0;
        return 1'b1;
    endfunction

    // cycle (counted from the accepting edge) in which done is expected
    function automatic int ref_cycles(input int v, input int w);
        int k;
        if (v < 4 || v % 2 == 0) return 2;
        k = 0;
        for (int dv = 3; ; dv += 2) begin
            if (dv * dv > v) return 3 + k * (w + 2);
            k++;
            if (v % dv == 0) return 2 + k * (w + 2);
        end
    endfunction

    function automatic logic o_busy(input bit w4);
        return w4 ? busy4 : busy8;
    endfunction
    function automatic logic o_done(input bit w4);
        return w4 ? done4 : done8;
    endfunction
    function automatic logic o_res(input bit w4);
        return w4 ? res4 : res8;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit w4, input bit s, input int v);
        if (w4) begin
            start4 = s;
            num4   = 4'(v);
        end else begin
            start8 = s;
            num8   = 8'(v);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; launches one operand.
    // poke: pulse start with num=4 at cycle 5 and in the done cycle, and scramble num.
    task automatic run_op(input bit w4, input int v, input bit poke, input string tag);
        int  cyc;
        int  exp_cyc;
        bit  exp_res;
        bit  res_early;
        exp_cyc   = ref_cycles(v, w4 ? 4 : 8);
        exp_res   = ref_prime(v);
        res_early = 1'b0;
        set_start(w4, 1'b1, v);
        @(posedge clk); #1;
        set_start(w4, 1'b0, v);
        cyc = 1;
        check({tag, "_busy_c1"}, o_busy(w4), 1);
        check({tag, "_res_clr"}, o_res(w4), 0);
        while (!o_done(w4) && cyc < 200) begin
            if (o_res(w4)) res_early = 1'b1;
            if (poke) begin
                start8 = (cyc == 5);
                num8   = (cyc == 5) ? 8'd4 : 8'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_res_busy"}, res_early, 0);
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_res"}, o_res(w4), exp_res);
        if (poke) begin
            start8 = 1'b1;
            num8   = 8'd4;
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        start4 = 1'b0;
        check({tag, "_done_pulse"}, o_done(w4), 0);
        check({tag, "_busy_end"}, o_busy(w4), 0);
        check({tag, "_res_hold"}, o_res(w4), exp_res);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start8 = 1'b1;
        start4 = 1'b1;
        num8   = 8'd7;
        num4   = 4'd7;

        // held in reset with start asserted: nothing may advance
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_res8", res8, 0);
        check("rst_busy4", busy4, 0);
        start8 = 1'b0;
        start4 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        check("idle_busy8", busy8, 0);

        run_op(1'b0, 7, 1'b0, "n7");

        for (int i = 0; i < 16; i++)
            run_op(1'b1, i, 1'b0, $sformatf("w4_n%0d", i));

        run_op(1'b0, 9,   1'b0, "n9");
        run_op(1'b0, 25,  1'b0, "n25");
        run_op(1'b0, 251, 1'b0, "n251");
        run_op(1'b0, 255, 1'b0, "n255");

        run_op(1'b0, 251, 1'b1, "busy_prot");

        // asynchronous reset in the middle of a division
        start8 = 1'b1;
        num8   = 8'd251;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("mid_busy_pre", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_res", res8, 0);
        start8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_hold", busy8, 0);
        start8 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 2, 1'b0, "after_rst_n2");

        // back-to-back: second start in the first idle cycle after done
        run_op(1'b0, 11, 1'b0, "b2b_n11");
        run_op(1'b0, 13, 1'b0, "b2b_n13");

        for (int i = 0; i < 30; i++)
            run_op(1'b0, int'($urandom_range(0, 255)), 1'b0, $sformatf("rand%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prime_checker_seq.md
# prime_checker_seq

Sequential, parametrised prime tester. Successor to the combinational 4-bit prime detector: the same `num`/`res` function for any operand width. It accepts one operand per start pulse and decides primality by trial division with a multi-cycle restoring divider. It reports the result with a one-cycle `done` pulse. It sits beside the arithmetic blocks as a slow, area-cheap checker driven by a controller FSM or a testbench.

## Interface
- `WIDTH`, default 8, operand width in bits; legal range 4 to 32.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `num`, input, WIDTH: operand, unsigned. Captured on the cycle `start` is accepted.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when `res` becomes valid.
- `res`, output, 1: 1 means prime, 0 means not prime. Valid from `done` until the next accepted start.

## Operation
- Registers:
  - `n`: WIDTH bits, the latched operand.
  - `d`: WIDTH bits, the current divisor.
  - Divider state: remainder (WIDTH+1 bits), quotient/shift register, bit counter.
- States: IDLE, INIT, SQ, DIV, REM, DONE.
- IDLE:
  - If `start` is high, latch `n = num`, clear `res`, go to INIT.
  - Otherwise stay in IDLE.
- INIT (1 cycle):
  - If n < 2, set res=0 and go to DONE.
  - Else if n ≤ 3, set res=1 and go to DONE.
  - Else if n[0] = 0, set res=0 and go to DONE.
  - Otherwise set d=3 and go to SQ.
- SQ (1 cycle):
  - Compute d·d at full 2·WIDTH width; it must not overflow.
  - If d·d > n, set res=1 and go to DONE.
  - Otherwise load the divider with n and d, and go to DIV.
- DIV (exactly WIDTH cycles): restoring division, one quotient bit per cycle, MSB first. After the WIDTH-th cycle go to REM.
- REM (1 cycle):
  - If the remainder is 0, set res=0 and go to DONE.
  - Otherwise set d = d+2 and go to SQ.
- DONE (1 cycle): `done`=1, then go to IDLE.
- Only odd divisors 3, 5, 7, … are tried. Even operands are rejected in INIT.
- `start` is ignored while `busy` is high, including in the DONE cycle. `num` changes after capture have no effect.
- `res` holds its value through IDLE until the next accepted `start`, then clears to 0.
- Reset at any time, including mid-division: go to IDLE and clear every register and output immediately.

## Timing
- Reset values: busy=0, done=0, res=0, state=IDLE, n=0, d=0.
- Let `start` be accepted at rising edge 0, with IDLE → INIT. INIT occupies cycle 1. `busy` rises after edge 0.
- Latency to `done` high, where k is the number of divisions performed:
  - Trivial (n<4 or even): `done` in cycle 2.
  - Prime (odd n ≥ 5): `done` in cycle 3 + k·(WIDTH+2).
  - Composite (odd): `done` in cycle 2 + k·(WIDTH+2). The k-th division yields remainder 0.
- `busy` falls on the edge after the DONE cycle. A new `start` is accepted earliest in that first IDLE cycle.
- `done` is never high for two consecutive cycles.
- Worst case: the largest prime below 2^WIDTH. For WIDTH=8, n=251: k=7 (d = 3…15), so `done` in cycle 73.

## Test plan
- Reset behaviour: assert `rst_n`=0 with `start`=1 → busy=0, done=0, res=0, and no state advance. Release reset, then pulse start with num=7 → `done` at cycle 3 (WIDTH=8; k=0 since 3·3>7) with res=1.
- WIDTH=4 exhaustive sweep: num = 0…15, one start per idle. `res`=1 exactly for {2,3,5,7,11,13}. num=15 → `done` at cycle 8 with res=0. num=0, 1, 2, 4 → `done` at cycle 2.
- WIDTH=8 latency checks:
  - n=9 → res=0, done at cycle 12.
  - n=25 → res=0, done at cycle 22.
  - n=251 → res=1, done at cycle 73.
  - n=255 → res=0, done at cycle 12.
- Busy protection: during n=251, pulse start with num=4 at cycles 5 and 73 → both ignored; the result stays res=1. `num` toggling after capture → no effect.
- Mid-operation reset: start n=251, assert rst_n=0 at cycle 30 → busy, done and res are 0 immediately. Then start n=2 → done at cycle 2 with res=1.
- Back-to-back: start n=13 in the first IDLE cycle after the previous `done` → accepted. `res` reads 0 while busy, then 1 at `done` (cycle 13 for WIDTH=8).
